// File: rtl/piece_mover_if.sv
// piece_mover_if: button, board-flag and render bundle for the piece mover.
// master is the board/renderer side, slave is the mover itself.
interface piece_mover_if;
  logic       start_over;
  logic       pause;
  logic       left_n;
  logic       right_n;
  logic       down_n;
  logic       rot_n;
  logic [3:0] level;
  logic [2:0] shape_w;
  logic [2:0] shape_h;
  logic       blk_left;
  logic       blk_right;
  logic       blk_below;
  logic       spawn_blk;
  logic [9:0] ref_x;
  logic [9:0] ref_y;
  logic       rotate_req;
  logic       lock_pulse;
  logic       game_over;

  modport master (
    output start_over, pause, left_n, right_n, down_n, rot_n,
    output level, shape_w, shape_h,
    output blk_left, blk_right, blk_below, spawn_blk,
    input  ref_x, ref_y, rotate_req, lock_pulse, game_over
  );

  modport slave (
    input  start_over, pause, left_n, right_n, down_n, rot_n,
    input  level, shape_w, shape_h,
    input  blk_left, blk_right, blk_below, spawn_blk,
    output ref_x, ref_y, rotate_req, lock_pulse, game_over
  );
endinterface

// File: rtl/piece_mover.sv
// piece_mover: falling-piece position, gravity, auto-repeat moves,
// rotation requests, lock and game-over for the Tetris playfield.
module piece_mover #(
  parameter int CELL      = 20,
  parameter int COLS      = 24,
  parameter int ROWS      = 24,
  parameter int SPAWN_COL = 14,
  parameter int TICK_BASE = 4500000,
  parameter int TICK_STEP = 500000,
  parameter int TICK_MIN  = 1000000,
  parameter int REPEAT    = 6000000,
  parameter int CNT_W     = 32
) (
  input  logic         iVGA_CLK,
  input  logic         reset,
  piece_mover_if.slave bus
);

  typedef enum logic [1:0] {FALL, LOCK, SPAWN, OVER} state_t;

  localparam logic [9:0] COLS_V  = 10'(COLS);
  localparam logic [9:0] ROWS_V  = 10'(ROWS);
  localparam logic [9:0] SPAWN_V = 10'(SPAWN_COL);
  localparam logic [9:0] RX_RST  = 10'(SPAWN_COL * CELL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BASE_V = CNT_W'(TICK_BASE);
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(TICK_STEP);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(TICK_MIN);
  localparam logic [CNT_W-1:0] REP_V  = CNT_W'(REPEAT);

  state_t           state_q, state_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [9:0]       rx_q, ry_q;
  logic [CNT_W-1:0] grav_q, grav_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             rot_q, rot_d;

  // button bit order {rot, down, right, left}
  logic [3:0] btn, s1_q, s2_q;
  // edge-detect bit order {rot, right, left}
  logic [2:0] s3_q, press_q, press_d;

  logic [CNT_W-1:0] red, base, period, per_eff;
  logic tick, rep_fire, l_held, r_held, both;
  logic mv_l, mv_r, can_l, can_r, bottom, clamp;

  assign btn = {bus.rot_n, bus.down_n, bus.right_n, bus.left_n};

  // two-flop synchronisers plus one delayed copy for 1->0 detection
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      s1_q    <= '1;
      s2_q    <= '1;
      s3_q    <= '1;
      press_q <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      s3_q    <= {s2_q[3], s2_q[1:0]};
      press_q <= press_d;
    end
  end

  // press edges, gravity period and move legality
  always_comb begin
    press_d = s3_q & ~{s2_q[3], s2_q[1:0]};
    if (bus.start_over || bus.pause) press_d = '0;

    red     = CNT_W'(bus.level) * STEP_V;
    base    = (red >= BASE_V) ? '0 : BASE_V - red;
    period  = (base < MIN_V) ? MIN_V : base;
    per_eff = s2_q[2] ? period : (period >> 2);
    tick    = (per_eff <= ONE) || (grav_q >= per_eff - ONE);

    l_held   = ~s3_q[0];
    r_held   = ~s3_q[1];
    both     = l_held & r_held;
    rep_fire = rep_q >= REP_V - ONE;
    mv_l     = ~both & (press_q[0] | (l_held & rep_fire));
    mv_r     = ~both & (press_q[1] | (r_held & rep_fire));
    can_l    = (col_q != '0) & ~bus.blk_left;
    can_r    = (col_q + 10'(bus.shape_w) < COLS_V) & ~bus.blk_right;
    bottom   = (row_q + 10'(bus.shape_h) >= ROWS_V) | bus.blk_below;
    clamp    = col_q + 10'(bus.shape_w) > COLS_V;
  end

  // next state, position and counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    grav_d  = grav_q;
    rep_d   = rep_q;
    rot_d   = 1'b0;
    if (bus.start_over) begin
      state_d = FALL;
      col_d   = SPAWN_V;
      row_d   = '0;
      grav_d  = '0;
      rep_d   = '0;
    end else if (!bus.pause) begin
      unique case (state_q)
        FALL: begin
          rot_d  = press_q[2];
          grav_d = grav_q + ONE;
          if (tick) begin
            grav_d = '0;
            if (bottom) state_d = LOCK;
            else row_d = row_q + 10'd1;
          end
          if (both || !(l_held || r_held)) rep_d = '0;
          else if (press_q[0] || press_q[1] || rep_fire) rep_d = '0;
          else rep_d = rep_q + ONE;
          if (clamp) col_d = COLS_V - 10'(bus.shape_w);
          else if (mv_l && can_l) col_d = col_q - 10'd1;
          else if (mv_r && can_r) col_d = col_q + 10'd1;
        end
        LOCK: begin
          state_d = SPAWN;
          rep_d   = '0;
        end
        SPAWN: begin
          col_d   = SPAWN_V;
          row_d   = '0;
          grav_d  = '0;
          state_d = bus.spawn_blk ? OVER : FALL;
        end
        OVER: begin
        end
      endcase
    end
  end

  // state, position, counters and registered pixel origin
  always_ff @(posedge iVGA_CLK or posedge reset) begin
    if (reset) begin
      state_q <= FALL;
      col_q   <= SPAWN_V;
      row_q   <= '0;
      grav_q  <= '0;
      rep_q   <= '0;
      rot_q   <= 1'b0;
      rx_q    <= RX_RST;
      ry_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      grav_q  <= grav_d;
      rep_q   <= rep_d;
      rot_q   <= rot_d;
      rx_q    <= 10'(col_d * CELL);
      ry_q    <= 10'(row_d * CELL);
    end
  end

  assign bus.ref_x      = rx_q;
  assign bus.ref_y      = ry_q;
  assign bus.rotate_req = rot_q;
  assign bus.lock_pulse = (state_q == LOCK) & ~bus.pause & ~bus.start_over;
  assign bus.game_over  = (state_q == OVER);

endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: directed checks of gravity, moves, lock, game over,
// pause and asynchronous reset with small timing parameters.
module tb_piece_mover;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  piece_mover_if bus();

  piece_mover #(
    .CELL(20), .COLS(24), .ROWS(24), .SPAWN_COL(14),
    .TICK_BASE(16), .TICK_STEP(4), .TICK_MIN(4),
    .REPEAT(8), .CNT_W(32)
  ) dut (
    .iVGA_CLK(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_idle();
    bus.start_over = 1'b0;
    bus.pause      = 1'b0;
    bus.left_n     = 1'b1;
    bus.right_n    = 1'b1;
    bus.down_n     = 1'b1;
    bus.rot_n      = 1'b1;
    bus.level      = 4'd0;
    bus.shape_w    = 3'd2;
    bus.shape_h    = 3'd2;
    bus.blk_left   = 1'b0;
    bus.blk_right  = 1'b0;
    bus.blk_below  = 1'b0;
    bus.spawn_blk  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_idle();
    step(2);
    chk("rst_ref_x", 32'(bus.ref_x), 280);
    chk("rst_ref_y", 32'(bus.ref_y), 0);
    chk("rst_rot", 32'(bus.rotate_req), 0);
    chk("rst_lock", 32'(bus.lock_pulse), 0);
    chk("rst_over", 32'(bus.game_over), 0);
    reset = 1'b0;

    // gravity: period 16, then level 5 -> 4, then soft drop -> 1
    step(15); chk("grav_e15", 32'(bus.ref_y), 0);
    step(1);  chk("grav_e16", 32'(bus.ref_y), 20);
    step(16); chk("grav_e32", 32'(bus.ref_y), 40);
    bus.level = 4'd5;
    step(3);  chk("lvl5_e35", 32'(bus.ref_y), 40);
    step(1);  chk("lvl5_e36", 32'(bus.ref_y), 60);
    step(4);  chk("lvl5_e40", 32'(bus.ref_y), 80);
    bus.down_n = 1'b0;
    step(2);  chk("soft_e42", 32'(bus.ref_y), 80);
    step(1);  chk("soft_e43", 32'(bus.ref_y), 100);
    step(1);  chk("soft_e44", 32'(bus.ref_y), 120);

    // floor lock with period 4
    do_reset();
    bus.level = 4'd15;
    step(88); chk("floor_y", 32'(bus.ref_y), 440);
    step(3);  chk("lock_early", 32'(bus.lock_pulse), 0);
    step(1);  chk("lock_pulse", 32'(bus.lock_pulse), 1);
    chk("lock_y_held", 32'(bus.ref_y), 440);
    step(1);  chk("lock_width", 32'(bus.lock_pulse), 0);
    step(1);  chk("spawn_x", 32'(bus.ref_x), 280);
    chk("spawn_y", 32'(bus.ref_y), 0);
    chk("spawn_over", 32'(bus.game_over), 0);
    step(4);  chk("refall_y", 32'(bus.ref_y), 20);

    // single left press, rotation, then held left with auto-repeat
    do_reset();
    bus.left_n = 1'b0; step(1); bus.left_n = 1'b1;
    step(2);  chk("left_e3", 32'(bus.ref_x), 280);
    step(1);  chk("left_e4", 32'(bus.ref_x), 260);
    step(10); chk("left_once", 32'(bus.ref_x), 260);
    bus.rot_n = 1'b0; step(1); bus.rot_n = 1'b1;
    step(2);  chk("rot_e3", 32'(bus.rotate_req), 0);
    step(1);  chk("rot_e4", 32'(bus.rotate_req), 1);
    step(1);  chk("rot_width", 32'(bus.rotate_req), 0);
    bus.left_n = 1'b0;
    step(3);  chk("hold_e3", 32'(bus.ref_x), 260);
    step(1);  chk("hold_e4", 32'(bus.ref_x), 240);
    step(7);  chk("hold_e11", 32'(bus.ref_x), 240);
    step(1);  chk("hold_e12", 32'(bus.ref_x), 220);
    step(8);  chk("hold_e20", 32'(bus.ref_x), 200);
    step(79); chk("hold_e99", 32'(bus.ref_x), 20);
    step(1);  chk("hold_e100", 32'(bus.ref_x), 0);
    step(20); chk("left_wall", 32'(bus.ref_x), 0);
    bus.left_n = 1'b1;

    // blocked right, both held, then a legal right press
    do_reset();
    bus.blk_right = 1'b1;
    bus.right_n = 1'b0; step(1); bus.right_n = 1'b1;
    step(6);  chk("blk_right", 32'(bus.ref_x), 280);
    bus.blk_right = 1'b0;
    bus.left_n = 1'b0; bus.right_n = 1'b0;
    step(20); chk("both_held", 32'(bus.ref_x), 280);
    bus.left_n = 1'b1; bus.right_n = 1'b1;
    step(4);
    bus.right_n = 1'b0; step(1); bus.right_n = 1'b1;
    step(3);  chk("right_ok", 32'(bus.ref_x), 300);

    // held right to the wall, then widen the piece to force a clamp
    do_reset();
    bus.right_n = 1'b0;
    step(59); chk("rhold_e59", 32'(bus.ref_x), 420);
    step(1);  chk("rhold_e60", 32'(bus.ref_x), 440);
    step(20); chk("right_wall", 32'(bus.ref_x), 440);
    bus.right_n = 1'b1;
    bus.shape_w = 3'd4;
    step(1);  chk("clamp", 32'(bus.ref_x), 400);

    // collision below locks on the first tick
    do_reset();
    bus.level = 4'd15;
    bus.blk_below = 1'b1;
    step(3);  chk("blkb_early", 32'(bus.lock_pulse), 0);
    step(1);  chk("blkb_lock", 32'(bus.lock_pulse), 1);
    chk("blkb_y", 32'(bus.ref_y), 0);

    // game over and restart
    do_reset();
    bus.level = 4'd15;
    bus.spawn_blk = 1'b1;
    step(94); chk("over_set", 32'(bus.game_over), 1);
    chk("over_y", 32'(bus.ref_y), 0);
    bus.left_n = 1'b0;
    step(12); chk("over_btn", 32'(bus.ref_x), 280);
    bus.left_n = 1'b1;
    step(20); chk("over_frz_y", 32'(bus.ref_y), 0);
    chk("over_stay", 32'(bus.game_over), 1);
    bus.spawn_blk = 1'b0;
    bus.start_over = 1'b1; step(1); bus.start_over = 1'b0;
    chk("restart", 32'(bus.game_over), 0);
    step(3);  chk("restart_e3", 32'(bus.ref_y), 0);
    step(1);  chk("restart_e4", 32'(bus.ref_y), 20);

    // pause freezes everything and drops edges
    do_reset();
    bus.level = 4'd15;
    step(6);  chk("pause_pre", 32'(bus.ref_y), 20);
    bus.pause = 1'b1;
    bus.left_n = 1'b0; bus.rot_n = 1'b0;
    step(2);
    bus.left_n = 1'b1; bus.rot_n = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step(1);
      chk("pause_hold",
          32'({bus.ref_x, bus.ref_y, bus.rotate_req, bus.lock_pulse}),
          32'({10'd280, 10'd20, 2'b00}));
    end
    bus.pause = 1'b0;
    step(1);  chk("resume_e1", 32'(bus.ref_y), 20);
    step(1);  chk("resume_e2", 32'(bus.ref_y), 40);
    chk("pause_drop", 32'(bus.ref_x), 280);

    // asynchronous reset in the middle of LOCK
    do_reset();
    bus.level = 4'd15;
    bus.left_n = 1'b0; step(1); bus.left_n = 1'b1;
    step(91); chk("pre_rst_lock", 32'(bus.lock_pulse), 1);
    chk("pre_rst_x", 32'(bus.ref_x), 260);
    #2 reset = 1'b1;
    #1;
    chk("arst_lock", 32'(bus.lock_pulse), 0);
    chk("arst_x", 32'(bus.ref_x), 280);
    chk("arst_y", 32'(bus.ref_y), 0);
    chk("arst_rot", 32'(bus.rotate_req), 0);
    chk("arst_over", 32'(bus.game_over), 0);
    step(1);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/piece_mover.md
# piece_mover

Parametrised falling-piece position controller for the VGA Tetris playfield. It owns the active piece's cell position and gravity timer, and applies level-based fall speed and soft drop. It also handles edge-detected horizontal moves with auto-repeat, rotation requests, lock detection and game-over. It sits between the debounced board buttons and collision logic on one side, and the pixel renderer, which consumes `ref_x`/`ref_y`, on the other.

## Interface
- `CELL`, 20: cell size in pixels.
- `COLS`, 24: playfield width in cells.
- `ROWS`, 24: playfield height in cells.
- `SPAWN_COL`, 14: spawn column, cell units.
- `TICK_BASE`, 4500000: gravity period at level 0, in clocks.
- `TICK_STEP`, 500000: period reduction per level.
- `TICK_MIN`, 1000000: period floor.
- `REPEAT`, 6000000: horizontal auto-repeat interval, in clocks.
- `CNT_W`, 32: width of the gravity and repeat counters.
- `iVGA_CLK` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start_over` in 1: synchronous restart, level-sensitive.
- `pause` in 1: freeze all motion and counters.
- `left_n`, `right_n`, `down_n`, `rot_n` in 1 each: active-low buttons, asynchronous to the clock.
- `level` in 4: speed level, 0–15.
- `shape_w`, `shape_h` in 3: current piece extent in cells, 1–4.
- `blk_left`, `blk_right`, `blk_below` in 1: collision flags from the board, valid for the current position.
- `spawn_blk` in 1: spawn position overlaps settled blocks.
- `ref_x`, `ref_y` out 10: piece origin in pixels (col·CELL, row·CELL).
- `rotate_req` out 1: one-cycle pulse.
- `lock_pulse` out 1: one-cycle pulse.
- `game_over` out 1: level output.

## Operation
- **Internal state:** `col`, `row` in cells.
  - `ref_x` = col·CELL and `ref_y` = row·CELL, both registered.
- **Input synchronisers:** each button passes through a 2-FF synchroniser.
  - A press is detected when the synchronised level goes 1→0.
- **States:** FALL, LOCK, SPAWN, OVER.
- **Priority:** `reset` > `start_over` > `pause` > state logic.
- **`start_over`:**
  - col=SPAWN_COL, row=0, counters cleared, `game_over`=0, state FALL.
- **`pause`:** col, row, both counters and the state are held.
  - No pulses are issued; edges seen during pause are discarded.
- **Gravity:**
  - period = max(TICK_BASE − level·TICK_STEP, TICK_MIN), computed in CNT_W bits with no underflow.
  - While `down_n` is held low (synchronised), period is divided by 4 (period>>2).
  - The counter increments every cycle; a tick fires when cnt ≥ period−1, then the counter is cleared.
  - If period shrinks below cnt, the tick fires immediately.
- **FALL on a tick:**
  - If row+shape_h == ROWS or `blk_below`: go to LOCK.
  - Otherwise row ← row+1. Exactly one row per tick, soft drop included.
- **Horizontal:**
  - A press edge moves one column immediately; the repeat counter is cleared.
  - While the button stays held, a further move fires each time the repeat counter reaches REPEAT−1.
  - Left moves only if col>0 and !`blk_left`.
  - Right moves only if col+shape_w < COLS and !`blk_right`.
  - Left and right held together: no move, repeat counter cleared.
  - A horizontal move and a gravity step in the same cycle both apply.
- **Rotation:** a `rot_n` press edge in FALL makes `rotate_req` = 1 for one cycle.
  - Rotation legality is checked externally.
- **LOCK:** lasts exactly one cycle, with `lock_pulse` = 1. Next state SPAWN.
- **SPAWN:**
  - col ← SPAWN_COL, row ← 0, gravity counter ← 0.
  - Next cycle: `spawn_blk` ? OVER : FALL.
- **OVER:**
  - `game_over` = 1 and the position is frozen; buttons are ignored.
  - Exit only via `start_over` or `reset`.
- **Column clamp:** if shape_w changes (rotation) so that col+shape_w > COLS, col ← COLS−shape_w on the next cycle.

## Timing
- **Reset values:**
  - `ref_x` = SPAWN_COL·CELL, `ref_y` = 0.
  - `rotate_req`, `lock_pulse`, `game_over` = 0.
  - State FALL; counters 0; synchroniser flops 1.
- **Button latency:** a button pin falling before rising edge k updates `ref_x` (or pulses `rotate_req`) on edge k+3.
- **Gravity latency:** a tick updates `ref_y` on the same edge the counter clears.
- **Lock sequence:**
  - LOCK follows the tick edge.
  - SPAWN follows one cycle later.
  - FALL or OVER follows one cycle after that.
  - Total: 3 cycles from tick to a moveable new piece.
- **Pulse width:** `lock_pulse` and `rotate_req` are never high for more than 1 consecutive cycle.
- **Asynchronous reset:** takes effect mid-operation, mid-LOCK or mid-SPAWN, without waiting for a clock.

## Test plan
Parameters for all scenarios: CELL=20, COLS=24, ROWS=24, SPAWN_COL=14, TICK_BASE=16, TICK_STEP=4, TICK_MIN=4, REPEAT=8.

- **Gravity period:** release reset, level=0, shape_h=2, buttons high.
  - `ref_y` steps 0→20→40 every 16 cycles.
  - level=5 → period 4; with `down_n`=0 → period 1.
- **Floor lock:** shape_h=2, let the piece fall freely.
  - At row 22 the next tick gives `lock_pulse` for 1 cycle.
  - 2 cycles later: `ref_x`=280, `ref_y`=0.
- **Left press and auto-repeat:** `left_n` pulsed low for 1 cycle at col 14.
  - `ref_x`=260 on the 3rd edge after the pulse.
  - Held for 20 cycles: moves at +3, +11, +19.
  - Stops at col 0 (`ref_x`=0).
- **Blocked moves:** `blk_right`=1 with `right_n` pressed → `ref_x` unchanged.
  - Both `left_n` and `right_n` held → no move.
- **Game over:** `spawn_blk`=1 during SPAWN.
  - `game_over`=1, `ref_y` frozen at 0, buttons ignored.
  - `start_over` for 1 cycle → `game_over`=0, state FALL.
- **Pause and async reset:** `pause`=1 for 50 cycles → `ref_x`/`ref_y` constant, no pulses.
  - Assert `reset` mid-LOCK → all outputs at reset values immediately.
